dual_port_ram_p: RTL and testbench

Parametrised simple dual-port RAM: one write port, one read port, one clock. It is the successor to the fixed 16x8 dual-port RAM and adds configurable width, depth and read latency, per-byte write enables, and a read-valid strobe. It also adds a hardware clear engine that zeroes the whole array after reset or on request. It sits behind FIFO, buffer and register-file logic as the team's standard on-chip storage block.

---
 rtl/dual_port_ram_p.sv | 184 ++++++++++++++++++
 tb/tb_dual_port_ram_p.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_p.sv
// -----------------------------------------------------------------------------
// dual_port_ram_p
//
// Parametrised simple dual-port RAM: one write port, one read port, one clock.
// Per-byte write enables, a registered read pipeline of RD_LAT stages with a
// read-valid strobe, and a clear engine that zeroes the whole array after
// reset or on request.
//
// Parameters
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  address width; DEPTH = 2**ADDR_W
//   RD_LAT  read latency in edges from the rd_en sampling edge (1 or 2)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset
//   wr_en      write request
//   w_addr     write address
//   w_data     write data
//   w_be       byte enables, bit i covers w_data[8i+7:8i]
//   rd_en      read request
//   rd_addr    read address
//   rd_data    registered read data, holds when no read completes
//   rd_valid   one-cycle strobe marking rd_data valid
//   clr_req    request a full-array clear
//   busy       clear in progress; wr_en/rd_en/clr_req ignored while high
//   fsm_state  debug view of the controller: 0 = CLEAR, 1 = READY
//
// Optional feature
//   DPRAM_BYPASS_EN  when defined, a same-address read and write on the same
//                    edge returns the merged (write-first) word; otherwise the
//                    read returns the old contents (read-first).
//
// Handshake: requests are single-cycle pulses sampled on the rising edge; a
// request is taken only when the controller is READY and clr_req is low on
// that edge. There is no backpressure; rd_valid is a strobe, not a handshake.
// -----------------------------------------------------------------------------
module dual_port_ram_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  fsm_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    // The clear counter is one bit wider than the address so the terminal
    // compare never aliases with a wrapped value.
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W:0]          clr_cnt;

    logic                     wr_fire;
    logic                     rd_fire;
    logic [DATA_W-1:0]        rd_word;

    logic [RD_LAT-1:0]              pipe_valid;
    logic [RD_LAT-1:0][DATA_W-1:0]  pipe_data;

    // A clr_req edge in READY drops any write or read sampled alongside it.
    assign wr_fire = (state == READY) && !clr_req && wr_en;
    assign rd_fire = (state == READY) && !clr_req && rd_en;

    assign busy      = (state == CLEAR);
    assign fsm_state = (state == READY);

    // -------------------------------------------------------------------------
    // Controller
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_CNT) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counts only while clearing; parks at zero in READY so a new
            // clear always starts from address 0.
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage: one array per byte lane, so each lane is a plain single-write
    // memory and byte enables need no read-modify-write.
    // -------------------------------------------------------------------------
    genvar b;
    generate
        for (b = 0; b < BE_W; b++) begin : g_lane
            logic [7:0] lane [DEPTH];

            always_ff @(posedge clk) begin
                if (state == CLEAR) begin
                    lane[clr_cnt[ADDR_W-1:0]] <= 8'h00;
                end else if (wr_fire && w_be[b]) begin
                    lane[w_addr] <= w_data[8*b +: 8];
                end
            end

`ifdef DPRAM_BYPASS_EN
            // Write-first: an enabled byte being written to the same address
            // this edge is forwarded straight into the read pipeline.
            assign rd_word[8*b +: 8] =
                (wr_fire && w_be[b] && (w_addr == rd_addr)) ? w_data[8*b +: 8]
                                                            : lane[rd_addr];
`else
            // Read-first: the read always sees the contents before this edge.
            assign rd_word[8*b +: 8] = lane[rd_addr];
`endif
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read pipeline. Stage 0 captures the word on the sampling edge; rd_data
    // and rd_valid load from the last stage one edge later, giving RD_LAT
    // edges from sampling to rd_valid. Captured reads keep flowing through a
    // clear, since their data was taken before the array was touched.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= '0;
            pipe_data  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            if (rd_fire) begin
                pipe_data[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
            rd_valid <= pipe_valid[RD_LAT-1];
            if (pipe_valid[RD_LAT-1]) begin
                rd_data <= pipe_data[RD_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram_p.sv
// -----------------------------------------------------------------------------
// tb_dual_port_ram_p
//
// Drives two instances of dual_port_ram_p from the same inputs: one with
// RD_LAT=2 (suffix 2) and one with RD_LAT=1 (suffix 1), both 16x16.
// Read results are checked by a monitor against per-instance expected queues;
// timing (busy, rd_valid) is checked in-line by the directed sequences.
// -----------------------------------------------------------------------------
module tb_dual_port_ram_p;

    localparam int DW = 16;
    localparam int AW = 4;

`ifdef DPRAM_BYPASS_EN
    localparam logic [15:0] COLL_FULL = 16'h5A5A;
    localparam logic [15:0] COLL_PART = 16'hABEE;
`else
    localparam logic [15:0] COLL_FULL = 16'h1111;
    localparam logic [15:0] COLL_PART = 16'hAB34;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic [DW/8-1:0]   w_be;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              clr_req;

    logic [DW-1:0]     rd_data2, rd_data1;
    logic              rd_valid2, rd_valid1;
    logic              busy2, busy1;
    logic              st2, st1;

    dual_port_ram_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .w_be(w_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2),
        .rd_valid(rd_valid2), .clr_req(clr_req), .busy(busy2), .fsm_state(st2)
    );

    dual_port_ram_p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .w_be(w_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1), .fsm_state(st1)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q2[$];
    logic [DW-1:0] exp_q1[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Every completed read must match the oldest expected value; a completion
    // with nothing expected is a read that should have been dropped.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_valid2) begin
                if (exp_q2.size() == 0) check_bit("rd2 unexpected valid", 1'b1, 1'b0);
                else                    check("rd2 data", rd_data2, exp_q2.pop_front());
            end
            if (rd_valid1) begin
                if (exp_q1.size() == 0) check_bit("rd1 unexpected valid", 1'b1, 1'b0);
                else                    check("rd1 data", rd_data1, exp_q1.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic rd, input logic [3:0] ra,
                         input logic clr);
        wr_en = wr; w_addr = wa; w_data = wd; w_be = be;
        rd_en = rd; rd_addr = ra; clr_req = clr;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic expect_rd(input logic [15:0] v);
        exp_q2.push_back(v);
        exp_q1.push_back(v);
    endtask

    task automatic drain(input string name);
        idle();
        repeat (4) step();
        check({name, " q2 empty"}, 16'(exp_q2.size()), 16'd0);
        check({name, " q1 empty"}, 16'(exp_q1.size()), 16'd0);
    endtask

    // Called right after reset release or the clr_req accept edge: busy must
    // stay high through 15 more edges and drop on the 16th. With noise set,
    // writes to addr 0 and reads of addr 9 are driven throughout.
    task automatic wait_clear(input string name, input logic noise);
        for (int i = 1; i <= 16; i++) begin
            if (noise) drive(1'b1, 4'd0, 16'hFFFF, 2'b11, 1'b1, 4'd9, 1'b0);
            step();
            check_bit({name, " busy2"}, busy2, (i < 16));
            check_bit({name, " busy1"}, busy1, (i < 16));
        end
        idle();
        check_bit({name, " ready2"}, st2, 1'b1);
        check_bit({name, " ready1"}, st1, 1'b1);
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 16'h8000 + 16'(i), 2'b11, 1'b0, 4'd0, 1'b0);
            step();
        end
        idle();
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(i), 1'b0);
            expect_rd(16'h0000);
            step();
        end
        drain(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        rd;
        logic [3:0]  ra;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  16'hABCD, 2'b11, 1'b0, 4'd0,  16'h0000};
        vecs[1]  = '{1'b1, 4'd5,  16'h1234, 2'b01, 1'b0, 4'd0,  16'h0000};
        vecs[2]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd5,  16'hAB34};
        vecs[3]  = '{1'b1, 4'd3,  16'h1111, 2'b11, 1'b0, 4'd0,  16'h0000};
        vecs[4]  = '{1'b1, 4'd9,  16'hBEEF, 2'b10, 1'b0, 4'd0,  16'h0000};
        vecs[5]  = '{1'b1, 4'd9,  16'h0000, 2'b00, 1'b1, 4'd9,  16'hBE00};
        vecs[6]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd9,  16'hBE00};
        vecs[7]  = '{1'b1, 4'd2,  16'hC3C3, 2'b11, 1'b1, 4'd5,  16'hAB34};
        vecs[8]  = '{1'b1, 4'd15, 16'h7E81, 2'b11, 1'b1, 4'd2,  16'hC3C3};
        vecs[9]  = '{1'b1, 4'd3,  16'h5A5A, 2'b11, 1'b1, 4'd3,  COLL_FULL};
        vecs[10] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd3,  16'h5A5A};
        vecs[11] = '{1'b1, 4'd5,  16'h00EE, 2'b01, 1'b1, 4'd5,  COLL_PART};
        vecs[12] = '{1'b1, 4'd0,  16'hFFFF, 2'b11, 1'b1, 4'd5,  16'hABEE};
        vecs[13] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd15, 16'h7E81};
        vecs[14] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd0,  16'hFFFF};
        vecs[15] = '{1'b0, 4'd0,  16'h0000, 2'b00, 1'b1, 4'd4,  16'h0000};
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        idle();
        step();
        step();

        // Reset state
        check("reset rd_data2", rd_data2, 16'h0000);
        check("reset rd_data1", rd_data1, 16'h0000);
        check_bit("reset rd_valid2", rd_valid2, 1'b0);
        check_bit("reset rd_valid1", rd_valid1, 1'b0);
        check_bit("reset busy2", busy2, 1'b1);
        check_bit("reset busy1", busy1, 1'b1);
        check_bit("reset state2", st2, 1'b0);

        // Clear after reset release
        rst = 1'b1;
        wait_clear("init clear", 1'b0);

        // Single read latency: sampled at edge N, RD_LAT=1 valid after N+1,
        // RD_LAT=2 valid after N+2.
        drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd0, 1'b0);
        expect_rd(16'h0000);
        step();
        idle();
        check_bit("lat N v2", rd_valid2, 1'b0);
        check_bit("lat N v1", rd_valid1, 1'b0);
        step();
        check_bit("lat N+1 v2", rd_valid2, 1'b0);
        check_bit("lat N+1 v1", rd_valid1, 1'b1);
        step();
        check_bit("lat N+2 v2", rd_valid2, 1'b1);
        check_bit("lat N+2 v1", rd_valid1, 1'b0);
        drain("latency");

        read_all_zero("post-reset zeros");

        // Table-driven writes, byte enables, collisions
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].rd, vecs[i].ra, 1'b0);
            if (vecs[i].rd) expect_rd(vecs[i].exp);
            step();
        end
        drain("table");

        // Back-to-back reads 0..3 on both latencies
        fill();
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(c), 1'b0);
                expect_rd(16'h8000 + 16'(c));
            end else begin
                idle();
            end
            step();
            check_bit("b2b v2", rd_valid2, (c >= 2) && (c <= 5));
            check_bit("b2b v1", rd_valid1, (c >= 1) && (c <= 4));
        end
        drain("b2b");

        // Reads in flight across a clear request; write/read on the accept
        // edge and during busy must be dropped.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'(c), 1'b0);
            expect_rd(16'h8000 + 16'(c));
            step();
        end
        drive(1'b1, 4'd7, 16'hFFFF, 2'b11, 1'b1, 4'd6, 1'b1);
        step();
        idle();
        check_bit("clr accept busy2", busy2, 1'b1);
        check_bit("clr accept busy1", busy1, 1'b1);
        wait_clear("clr_req clear", 1'b1);
        drain("in-flight");
        read_all_zero("post-clr zeros");

        // Reset while a read is in flight
        drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd2, 1'b0);
        @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #2;
        check_bit("pre-reset v1", rd_valid1, 1'b1);
        rst = 1'b0;
        #1;
        check_bit("rd reset v1", rd_valid1, 1'b0);
        check_bit("rd reset v2", rd_valid2, 1'b0);
        check("rd reset data1", rd_data1, 16'h0000);
        check_bit("rd reset busy2", busy2, 1'b1);
        step();
        step();
        rst = 1'b1;
        wait_clear("clear after read reset", 1'b0);
        drain("read reset");

        // Reset in the middle of a clear (clr_cnt = 8)
        fill();
        drive(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1);
        step();
        idle();
        repeat (8) step();
        rst = 1'b0;
        #1;
        check_bit("mid reset v2", rd_valid2, 1'b0);
        check_bit("mid reset v1", rd_valid1, 1'b0);
        check_bit("mid reset busy2", busy2, 1'b1);
        check_bit("mid reset busy1", busy1, 1'b1);
        step();
        rst = 1'b1;
        wait_clear("restarted clear", 1'b0);
        read_all_zero("post-restart zeros");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
